pe_sequencer: RTL

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pe_sequencer.sv
// Sequencer for a dot-product processing element. It clears the PE, loads the A and B
// vectors from the operand stream, runs the MAC, and hands the result to the consumer.
`timescale 1ns/1ps

module pe_sequencer (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [1:0]  DIM,
    input  logic [31:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [31:0] RES_DATA,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic        BUSY,
    output logic [31:0] PE_DATAIN,
    output logic        PE_WRITE_MAT,
    output logic        PE_MAT_MUX,
    output logic        PE_RST_ADD,
    output logic        PE_RST_PC,
    output logic        PE_RST_ACC,
    output logic        PE_MAC_CTRL,
    output logic        PE_OUT_READY,
    output logic [1:0]  PE_DIMEN,
    input  logic        PE_MAC_DONE,
    input  logic [31:0] PE_DATAOUT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOAD_A = 3'd2,
        ADDR_B = 3'd3,
        LOAD_B = 3'd4,
        MAC    = 3'd5,
        READ   = 3'd6,
        RESP   = 3'd7
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  dim_q_reg, dim_q_next;
    logic [4:0]  word_cnt_reg, word_cnt_next;
    logic [4:0]  mac_cnt_reg, mac_cnt_next;
    logic [31:0] res_data_reg, res_data_next;

    logic [4:0]  last_idx;
    logic        in_ready;
    logic        accept;

    // L-1 for L = 2, 4, 8, 16
    assign last_idx = (5'd2 << dim_q_reg) - 5'd1;
    assign in_ready = RSTN && ((state_reg == LOAD_A) || (state_reg == LOAD_B));
    assign accept   = IN_VALID && in_ready;

    assign IN_READY     = in_ready;
    assign PE_WRITE_MAT = accept;
    assign PE_DATAIN    = IN_DATA;
    assign PE_DIMEN     = RSTN ? dim_q_reg : 2'd0;
    assign RES_DATA     = res_data_reg;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg    <= IDLE;
            dim_q_reg    <= 2'd0;
            word_cnt_reg <= 5'd0;
            mac_cnt_reg  <= 5'd0;
            res_data_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            dim_q_reg    <= dim_q_next;
            word_cnt_reg <= word_cnt_next;
            mac_cnt_reg  <= mac_cnt_next;
            res_data_reg <= res_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dim_q_next    = dim_q_reg;
        word_cnt_next = word_cnt_reg;
        mac_cnt_next  = mac_cnt_reg;
        res_data_next = res_data_reg;
        RES_VALID     = 1'b0;
        BUSY          = 1'b0;
        PE_MAT_MUX    = 1'b0;
        PE_RST_ADD    = 1'b0;
        PE_RST_PC     = 1'b0;
        PE_RST_ACC    = 1'b0;
        PE_MAC_CTRL   = 1'b0;
        PE_OUT_READY  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (START) begin
                    dim_q_next = DIM;
                    state_next = CLR;
                end
            end
            CLR: begin
                BUSY          = 1'b1;
                PE_RST_ADD    = 1'b1;
                PE_RST_PC     = 1'b1;
                PE_RST_ACC    = 1'b1;
                word_cnt_next = 5'd0;
                state_next    = LOAD_A;
            end
            LOAD_A: begin
                BUSY       = 1'b1;
                PE_MAT_MUX = 1'b1;
                if (accept) begin
                    if (word_cnt_reg == last_idx) begin
                        word_cnt_next = 5'd0;
                        state_next    = ADDR_B;
                    end else begin
                        word_cnt_next = word_cnt_reg + 5'd1;
                    end
                end
            end
            ADDR_B: begin
                // The PE's address reset beats a write, so B loading starts one cycle later
                BUSY          = 1'b1;
                PE_RST_ADD    = 1'b1;
                word_cnt_next = 5'd0;
                state_next    = LOAD_B;
            end
            LOAD_B: begin
                BUSY = 1'b1;
                if (accept) begin
                    if (word_cnt_reg == last_idx) begin
                        word_cnt_next = 5'd0;
                        mac_cnt_next  = 5'd0;
                        state_next    = MAC;
                    end else begin
                        word_cnt_next = word_cnt_reg + 5'd1;
                    end
                end
            end
            MAC: begin
                // Own cycle count guards against a PE that never raises MAC_DONE
                BUSY         = 1'b1;
                PE_MAC_CTRL  = 1'b1;
                mac_cnt_next = mac_cnt_reg + 5'd1;
                if (PE_MAC_DONE || (mac_cnt_reg == last_idx)) begin
                    state_next = READ;
                end
            end
            READ: begin
                BUSY          = 1'b1;
                PE_OUT_READY  = 1'b1;
                res_data_next = PE_DATAOUT;
                state_next    = RESP;
            end
            RESP: begin
                BUSY      = 1'b1;
                RES_VALID = 1'b1;
                if (RES_READY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Hold the PE in its cleared state for as long as reset is asserted
        if (!RSTN) begin
            RES_VALID    = 1'b0;
            BUSY         = 1'b0;
            PE_MAT_MUX   = 1'b0;
            PE_MAC_CTRL  = 1'b0;
            PE_OUT_READY = 1'b0;
            PE_RST_ADD   = 1'b1;
            PE_RST_PC    = 1'b1;
            PE_RST_ACC   = 1'b1;
        end
    end

endmodule
